// File: rtl/interval_timer_arbiter.sv
// Two-client round-robin arbiter around one shared interval counter.
// The winner's length is latched on grant; done pulses once when the count reaches it.
module interval_timer_arbiter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [W-1:0] len0,
  input  logic [W-1:0] len1,
  input  logic         tick,
  input  logic         abort,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic [1:0]   done,
  output logic [W-1:0] count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t       state, state_d;
  logic [W-1:0] lim, lim_d, count_d;
  logic [1:0]   gnt_d, done_d;
  logic         busy_d, last, last_d;
  logic         granted, winner, cancel;

  // gnt is one-hot whenever a client is being served, so its upper bit names that client
  assign granted = gnt[1];
  assign winner  = (req == 2'b11) ? ~last : req[1];
  assign cancel  = abort | ~req[granted];

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    done_d  = 2'b00;
    busy_d  = busy;
    count_d = count;
    lim_d   = lim;
    last_d  = last;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_d = LOAD;
          gnt_d   = winner ? 2'b10 : 2'b01;
          lim_d   = winner ? len1 : len0;
          busy_d  = 1'b1;
        end
      end
      LOAD, RUN: begin
        if (cancel) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          busy_d  = 1'b0;
          last_d  = granted;
        end else if (state == LOAD) begin
          state_d = RUN;
          count_d = '0;
        end else if (count == lim) begin
          // expiry wins over tick, which is what keeps count from ever passing lim
          state_d = DONE;
          done_d  = granted ? 2'b10 : 2'b01;
        end else if (tick) begin
          count_d = count + W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        last_d  = granted;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= 2'b00;
      done  <= 2'b00;
      busy  <= 1'b0;
      count <= '0;
      lim   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      done  <= done_d;
      busy  <= busy_d;
      count <= count_d;
      lim   <= lim_d;
      last  <= last_d;
    end
  end

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Self-checking bench for interval_timer_arbiter: directed scenarios plus randomized
// intervals checked against a tick-counting reference model.
module tb_interval_timer_arbiter;
  localparam int W    = 12;
  localparam int MAXE = 4300;

  logic         clk = 1'b0;
  logic         reset, tick, abort, busy;
  logic [1:0]   req, gnt, done;
  logic [W-1:0] len0, len1, count;

  int total = 0;
  int bad   = 0;
  int exp_last;

  // tk[e] is the tick value presented before edge e; o*[e] are outputs seen after edge e
  bit           tk [0:MAXE];
  logic [1:0]   og [0:MAXE];
  logic [1:0]   od [0:MAXE];
  logic         ob [0:MAXE];
  logic [W-1:0] oc [0:MAXE];

  interval_timer_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .tick(tick), .abort(abort), .gnt(gnt), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] oh(input int c);
    return (c != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic make_ticks(input bit all_high);
    for (int e = 0; e <= MAXE; e++)
      tk[e] = all_high ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  // Reference: counting starts on the third edge; done lands one edge after the len-th tick
  function automatic int exp_done(input int len);
    int ones;
    ones = 0;
    if (len == 0) return 3;
    for (int e = 3; e <= MAXE; e++) begin
      if (tk[e]) ones++;
      if (ones == len) return e + 1;
    end
    return -1;
  endfunction

  // Acts as the client: drops its request when its done pulse appears
  task automatic record(input int n, input bit scramble);
    for (int e = 1; e <= n; e++) begin
      tick = tk[e];
      step();
      og[e] = gnt; od[e] = done; ob[e] = busy; oc[e] = count;
      req = req & ~done;
      if (scramble && e == 1) begin
        len0 = W'($urandom);
        len1 = W'($urandom);
      end
    end
    tick = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_last = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req = 2'($urandom); len0 = W'($urandom); len1 = W'($urandom);
      tick = 1'($urandom); abort = 1'($urandom);
      step();
      total++; if (gnt !== 2'b00) begin bad++; $display("[TB] FAIL reset_gnt: got %b expected 00", gnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      total++; if (done !== 2'b00) begin bad++; $display("[TB] FAIL reset_done: got %b expected 00", done); end
      total++; if (count !== '0) begin bad++; $display("[TB] FAIL reset_count: got %h expected 000", count); end
    end
    req = 2'b00; tick = 1'b0; abort = 1'b0; len0 = '0; len1 = '0;
    reset = 1'b1;
    exp_last = 1;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    req = 2'b01; len0 = 12'd3; len1 = W'($urandom);
    make_ticks(1'b1);
    record(7, 1'b0);
    req = 2'b00;
    total++; if (og[1] !== 2'b01) begin bad++; $display("[TB] FAIL single_gnt: got %b expected 01", og[1]); end
    for (int e = 2; e <= 5; e++) begin
      total++;
      if (oc[e] !== W'(e - 2)) begin bad++; $display("[TB] FAIL single_count_e%0d: got %h expected %h", e, oc[e], e - 2); end
    end
    total++; if (od[5] !== 2'b00) begin bad++; $display("[TB] FAIL single_done_early: got %b expected 00", od[5]); end
    total++; if (od[6] !== 2'b01) begin bad++; $display("[TB] FAIL single_done: got %b expected 01", od[6]); end
    total++; if (ob[6] !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_done: got %b expected 1", ob[6]); end
    total++; if (od[7] !== 2'b00) begin bad++; $display("[TB] FAIL single_done_width: got %b expected 00", od[7]); end
    total++; if (ob[7] !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_after: got %b expected 0", ob[7]); end
    exp_last = 0;
  endtask

  task automatic test_contention();
    pulse_reset();
    req = 2'b11; len0 = 12'd2; len1 = 12'd4;
    make_ticks(1'b1);
    record(14, 1'b0);
    req = 2'b00;
    total++; if (og[1] !== 2'b01) begin bad++; $display("[TB] FAIL cont_first_gnt: got %b expected 01", og[1]); end
    total++; if (od[5] !== 2'b01) begin bad++; $display("[TB] FAIL cont_first_done: got %b expected 01", od[5]); end
    total++; if (og[6] !== 2'b00) begin bad++; $display("[TB] FAIL cont_gap_gnt: got %b expected 00", og[6]); end
    total++; if (og[7] !== 2'b10) begin bad++; $display("[TB] FAIL cont_second_gnt: got %b expected 10", og[7]); end
    total++; if (od[13] !== 2'b10) begin bad++; $display("[TB] FAIL cont_second_done: got %b expected 10", od[13]); end
    total++; if (ob[14] !== 1'b0) begin bad++; $display("[TB] FAIL cont_busy_after: got %b expected 0", ob[14]); end
    exp_last = 1;
    req = 2'b11; len0 = 12'd2;
    record(6, 1'b0);
    req = 2'b00;
    total++; if (og[1] !== 2'b01) begin bad++; $display("[TB] FAIL cont_again_gnt: got %b expected 01", og[1]); end
    total++; if (od[5] !== 2'b01) begin bad++; $display("[TB] FAIL cont_again_done: got %b expected 01", od[5]); end
    exp_last = 0;
  endtask

  task automatic test_tick_gaps();
    int fd;
    req = 2'b10; len1 = 12'd2;
    for (int e = 0; e <= MAXE; e++) tk[e] = (e % 2 == 0);
    record(8, 1'b0);
    req = 2'b00;
    fd = -1;
    for (int e = 1; e <= 8; e++) if (fd < 0 && od[e] !== 2'b00) fd = e;
    total++; if (fd != 7) begin bad++; $display("[TB] FAIL gap_done_cycle: got %0d expected 7", fd); end
    total++; if (od[7] !== 2'b10) begin bad++; $display("[TB] FAIL gap_done_value: got %b expected 10", od[7]); end
    exp_last = 1;
    req = 2'b01; len0 = 12'd0;
    make_ticks(1'b1);
    record(4, 1'b0);
    req = 2'b00;
    total++; if (oc[2] !== '0) begin bad++; $display("[TB] FAIL zero_count: got %h expected 000", oc[2]); end
    total++; if (od[2] !== 2'b00) begin bad++; $display("[TB] FAIL zero_done_early: got %b expected 00", od[2]); end
    total++; if (od[3] !== 2'b01) begin bad++; $display("[TB] FAIL zero_done: got %b expected 01", od[3]); end
    total++; if (ob[4] !== 1'b0) begin bad++; $display("[TB] FAIL zero_busy_after: got %b expected 0", ob[4]); end
    exp_last = 0;
  endtask

  task automatic test_abort();
    int w;
    bit hit;
    w = 1 - exp_last;
    req = 2'b11; len0 = 12'd20; len1 = 12'd20; tick = 1'b1; hit = 1'b0;
    for (int e = 1; e <= 30 && !hit; e++) begin
      step();
      if (e >= 2 && count == 12'd5) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("[TB] FAIL abort_reach_count5: got %h expected 005", count); end
    abort = 1'b1; req = 2'b00;
    step();
    abort = 1'b0;
    total++; if (gnt !== 2'b00) begin bad++; $display("[TB] FAIL abort_gnt: got %b expected 00", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    total++; if (done !== 2'b00) begin bad++; $display("[TB] FAIL abort_done: got %b expected 00", done); end
    total++; if (count !== 12'd5) begin bad++; $display("[TB] FAIL abort_count_hold: got %h expected 005", count); end
    exp_last = w;
    req = 2'b11;
    step();
    total++; if (gnt !== oh(1 - exp_last)) begin bad++; $display("[TB] FAIL abort_next_winner: got %b expected %b", gnt, oh(1 - exp_last)); end
    step(); step(); step();
    req = oh(w);
    step();
    total++; if (gnt !== 2'b00) begin bad++; $display("[TB] FAIL drop_gnt: got %b expected 00", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL drop_busy: got %b expected 0", busy); end
    total++; if (done !== 2'b00) begin bad++; $display("[TB] FAIL drop_done: got %b expected 00", done); end
    exp_last = 1 - w;
    req = 2'b11;
    step();
    total++; if (gnt !== oh(1 - exp_last)) begin bad++; $display("[TB] FAIL drop_next_winner: got %b expected %b", gnt, oh(1 - exp_last)); end
    abort = 1'b1; req = 2'b00;
    step();
    abort = 1'b0; tick = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_in_load_busy: got %b expected 0", busy); end
    exp_last = w;
  endtask

  task automatic test_boundary();
    int early, cerr, ones, expc;
    req = 2'b01; len0 = 12'hFFF;
    make_ticks(1'b1);
    record(4099, 1'b1);
    req = 2'b00;
    early = 0; cerr = 0; ones = 0;
    for (int e = 1; e <= 4097; e++) if (od[e] !== 2'b00) early++;
    for (int e = 2; e <= 4097; e++) begin
      if (e >= 3 && tk[e]) ones++;
      expc = (ones < 4095) ? ones : 4095;
      if (oc[e] !== W'(expc)) cerr++;
    end
    total++; if (og[1] !== 2'b01) begin bad++; $display("[TB] FAIL max_gnt: got %b expected 01", og[1]); end
    total++; if (early != 0) begin bad++; $display("[TB] FAIL max_early_done: got %0d expected 0", early); end
    total++; if (cerr != 0) begin bad++; $display("[TB] FAIL max_count_trace: got %0d errors expected 0", cerr); end
    total++; if (oc[4097] !== 12'hFFF) begin bad++; $display("[TB] FAIL max_count_top: got %h expected fff", oc[4097]); end
    total++; if (od[4098] !== 2'b01) begin bad++; $display("[TB] FAIL max_done: got %b expected 01", od[4098]); end
    total++; if (oc[4098] !== 12'hFFF) begin bad++; $display("[TB] FAIL max_no_wrap: got %h expected fff", oc[4098]); end
    total++; if (ob[4099] !== 1'b0) begin bad++; $display("[TB] FAIL max_busy_after: got %b expected 0", ob[4099]); end
    exp_last = 0;
    req = 2'b10; len1 = 12'd50;
    record(10, 1'b0);
    reset = 1'b0;
    #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("[TB] FAIL midreset_gnt: got %b expected 00", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    total++; if (count !== '0) begin bad++; $display("[TB] FAIL midreset_count: got %h expected 000", count); end
    step(); step();
    total++; if (done !== 2'b00) begin bad++; $display("[TB] FAIL midreset_done: got %b expected 00", done); end
    reset = 1'b1; exp_last = 1;
    req = 2'b11;
    step();
    total++; if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL midreset_last: got %b expected 01", gnt); end
    abort = 1'b1; req = 2'b00;
    step();
    abort = 1'b0;
    exp_last = 0;
  endtask

  task automatic test_random();
    int w, len, d, early, cerr, ones, expc;
    logic [1:0] rq;
    for (int it = 0; it < 20; it++) begin
      rq   = 2'($urandom_range(1, 3));
      len0 = W'($urandom_range(0, 30));
      len1 = W'($urandom_range(0, 30));
      w    = (rq == 2'b11) ? 1 - exp_last : ((rq == 2'b10) ? 1 : 0);
      len  = (w != 0) ? int'(len1) : int'(len0);
      make_ticks(1'b0);
      d = exp_done(len);
      if (d < 3 || d >= MAXE) d = 200;
      req = rq;
      record(d + 1, 1'b1);
      req = 2'b00;
      early = 0; cerr = 0; ones = 0;
      for (int e = 1; e < d; e++) if (od[e] !== 2'b00) early++;
      for (int e = 2; e < d; e++) begin
        if (e >= 3 && tk[e]) ones++;
        expc = (ones < len) ? ones : len;
        if (oc[e] !== W'(expc)) cerr++;
      end
      total++; if (og[1] !== oh(w)) begin bad++; $display("[TB] FAIL rnd%0d_gnt: got %b expected %b", it, og[1], oh(w)); end
      total++; if (early != 0) begin bad++; $display("[TB] FAIL rnd%0d_early_done: got %0d expected 0", it, early); end
      total++; if (cerr != 0) begin bad++; $display("[TB] FAIL rnd%0d_count_trace: got %0d errors expected 0", it, cerr); end
      total++; if (od[d] !== oh(w)) begin bad++; $display("[TB] FAIL rnd%0d_done: got %b expected %b", it, od[d], oh(w)); end
      total++; if (ob[d + 1] !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_busy_after: got %b expected 0", it, ob[d + 1]); end
      exp_last = w;
    end
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; len0 = '0; len1 = '0; tick = 1'b0; abort = 1'b0;
    exp_last = 1;
    #2;
    test_reset();
    test_single();
    test_contention();
    test_tick_gaps();
    test_abort();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
